// File: rtl/instr_cycle_sequencer.sv
// -----------------------------------------------------------------------------
// instr_cycle_sequencer
//   Multi-cycle control FSM for the CPU datapath. It steps each instruction
//   through fetch, decode, execute, memory and writeback. It waits out the
//   synchronous ROM and RAM latencies, and it issues one-cycle strobes to the
//   PC, the IR, the register file and the RAM.
//
//   Every output is registered. A strobe decided in a state therefore appears
//   in the cycle after that state. For example, the retire strobes of an
//   instruction are high during the S_IF cycle that follows it.
//
//   Optional feature macro: SINGLE_STEP_EN
//     Adds a `step` input. While parked in S_IF with run low, a step pulse
//     starts exactly one instruction.
//
// Parameters
//   CNT_W     width of the retired-instruction counter
//   MEM_WAIT  RAM read latency in cycles (1..3)
//
// Ports
//   clk               system clock
//   reset             synchronous, active-low reset
//   run               1 = keep starting instructions, 0 = park in S_IF
//   step              (SINGLE_STEP_EN only) single-instruction start pulse
//   is_alu .. is_halt decoded instruction class flags
//   branch_taken      branch condition, sampled in S_EX
//   ir_load           latch the ROM output into the IR
//   pc_update         PC write strobe
//   pc_sel_target     with pc_update: 1 = target, 0 = pc+1
//   reg_write_enable  register file write strobe
//   ram_read_enable   RAM rden
//   ram_write_enable  RAM wren
//   busy              state != S_IF
//   halted            state == S_HALT
//   instr_count       retired-instruction counter (wraps)
//
// state  | meaning
// S_IF   | idle / fetch issue; waits for run (or step)
// S_IFW  | ROM latency cycle, IR load decided here
// S_ID   | decode class, NOPs retire here
// S_EX   | branch/j/jr retire; others route to S_MEM or S_WB
// S_MEM  | store writes and retires; load issues the RAM read
// S_MW   | RAM read latency countdown
// S_WB   | register write and retire
// S_HALT | absorbing halt, left only through reset
// -----------------------------------------------------------------------------
module instr_cycle_sequencer #(
  parameter int CNT_W    = 16,
  parameter int MEM_WAIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
`ifdef SINGLE_STEP_EN
  input  logic             step,
`endif
  input  logic             is_alu,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             is_branch,
  input  logic             is_jump,
  input  logic             is_jal,
  input  logic             is_halt,
  input  logic             branch_taken,
  output logic             ir_load,
  output logic             pc_update,
  output logic             pc_sel_target,
  output logic             reg_write_enable,
  output logic             ram_read_enable,
  output logic             ram_write_enable,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IF, S_IFW, S_ID, S_EX, S_MEM, S_MW, S_WB, S_HALT
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] wait_q, wait_d;
  logic       load_q, load_d;     // remembers load vs store across S_MEM
  logic       ir_load_d, pc_update_d, pc_sel_d, reg_wr_d, ram_rd_d, ram_wr_d;
  logic       start;

`ifdef SINGLE_STEP_EN
  // step only matters in S_IF; the FSM ignores it while busy.
  assign start = run | step;
`else
  assign start = run;
`endif

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    load_d      = load_q;
    ir_load_d   = 1'b0;
    pc_update_d = 1'b0;
    pc_sel_d    = 1'b0;
    reg_wr_d    = 1'b0;
    ram_rd_d    = 1'b0;
    ram_wr_d    = 1'b0;
    case (state_q)
      S_IF: if (start) state_d = S_IFW;
      S_IFW: begin
        ir_load_d = 1'b1;
        state_d   = S_ID;
      end
      S_ID: begin
        if (is_halt) state_d = S_HALT;
        else if (is_jump | is_branch | is_load | is_store | is_alu) state_d = S_EX;
        else begin
          // No class flag set: treat as a NOP.
          pc_update_d = 1'b1;
          state_d     = S_IF;
        end
      end
      S_EX: begin
        if (is_jump) begin
          if (is_jal) state_d = S_WB;
          else begin
            pc_update_d = 1'b1;
            pc_sel_d    = 1'b1;
            state_d     = S_IF;
          end
        end else if (is_branch) begin
          pc_update_d = 1'b1;
          pc_sel_d    = branch_taken;
          state_d     = S_IF;
        end else if (is_load | is_store) begin
          load_d  = is_load;
          state_d = S_MEM;
        end else state_d = S_WB;
      end
      S_MEM: begin
        if (load_q) begin
          ram_rd_d = 1'b1;
          wait_d   = 2'(MEM_WAIT);
          state_d  = S_MW;
        end else begin
          ram_wr_d    = 1'b1;
          pc_update_d = 1'b1;
          state_d     = S_IF;
        end
      end
      S_MW: begin
        // Keeping rden asserted on the exit edge covers the S_WB cycle,
        // where the RAM output is captured into the register file.
        ram_rd_d = 1'b1;
        wait_d   = wait_q - 2'd1;
        if (wait_q == 2'd1) state_d = S_WB;
      end
      S_WB: begin
        reg_wr_d    = 1'b1;
        pc_update_d = 1'b1;
        pc_sel_d    = is_jump & is_jal;
        state_d     = S_IF;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q          <= S_IF;
      wait_q           <= 2'd0;
      load_q           <= 1'b0;
      ir_load          <= 1'b0;
      pc_update        <= 1'b0;
      pc_sel_target    <= 1'b0;
      reg_write_enable <= 1'b0;
      ram_read_enable  <= 1'b0;
      ram_write_enable <= 1'b0;
      busy             <= 1'b0;
      halted           <= 1'b0;
      instr_count      <= '0;
    end else begin
      state_q          <= state_d;
      wait_q           <= wait_d;
      load_q           <= load_d;
      ir_load          <= ir_load_d;
      pc_update        <= pc_update_d;
      pc_sel_target    <= pc_sel_d;
      reg_write_enable <= reg_wr_d;
      ram_read_enable  <= ram_rd_d;
      ram_write_enable <= ram_wr_d;
      busy             <= (state_d != S_IF);
      halted           <= (state_d == S_HALT);
      // Counter steps on the same edge that raises that instruction's pc_update.
      if (pc_update_d) instr_count <= instr_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_instr_cycle_sequencer.sv
module tb_instr_cycle_sequencer;
  localparam int CNT_W    = 5;
  localparam int MEM_WAIT = 3;
  localparam int MAXC     = 4096;

  localparam int C_NOP = 0, C_ALU = 1, C_LOAD = 2, C_STORE = 3,
                 C_BR  = 4, C_J   = 5, C_JAL  = 6, C_HALT  = 7;

  logic clk = 1'b0;
  logic reset, run, branch_taken;
  logic is_alu, is_load, is_store, is_branch, is_jump, is_jal, is_halt;
`ifdef SINGLE_STEP_EN
  logic step;
`endif
  logic ir_load, pc_update, pc_sel_target, reg_write_enable;
  logic ram_read_enable, ram_write_enable, busy, halted;
  logic [CNT_W-1:0] instr_count;

  always #5 clk = ~clk;

  instr_cycle_sequencer #(.CNT_W(CNT_W), .MEM_WAIT(MEM_WAIT)) dut (
    .clk(clk), .reset(reset), .run(run),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .is_alu(is_alu), .is_load(is_load), .is_store(is_store),
    .is_branch(is_branch), .is_jump(is_jump), .is_jal(is_jal),
    .is_halt(is_halt), .branch_taken(branch_taken),
    .ir_load(ir_load), .pc_update(pc_update), .pc_sel_target(pc_sel_target),
    .reg_write_enable(reg_write_enable), .ram_read_enable(ram_read_enable),
    .ram_write_enable(ram_write_enable), .busy(busy), .halted(halted),
    .instr_count(instr_count)
  );

  // Per-cycle plan: inputs to drive and outputs to expect.
  // Flag bits: {halt, jal, jump, branch, store, load, alu}.
  // Output bits: {halted, busy, wren, rden, regwr, sel, pcu, irld}.
  logic       in_run [MAXC];
  logic       in_rst [MAXC];
  logic       in_bt  [MAXC];
  logic [6:0] in_fl  [MAXC];
`ifdef SINGLE_STEP_EN
  logic       in_step[MAXC];
`endif
  logic [7:0] ex_o   [MAXC];
  int         ex_cnt [MAXC];

  int t, m_cnt, cur_cyc;
  bit p_pcu, p_sel, p_rw, p_wr;
  int vectors = 0, miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cur_cyc, obs, exp);
    end
  endtask

  function automatic int ins_len(input int c);
    case (c)
      C_NOP, C_HALT:         return 3;
      C_BR, C_J:             return 4;
      C_LOAD:                return 6 + MEM_WAIT;
      default:               return 5;
    endcase
  endfunction

  // Class flags with random noise on lower-priority flags.
  function automatic logic [6:0] cls_flags(input int c);
    logic [6:0] n;
    n = 7'($urandom);
    case (c)
      C_HALT:  return {1'b1, n[5:0]};
      C_JAL:   return {3'b011, n[3:0]};
      C_J:     return {3'b001, n[3:0]};
      C_BR:    return {1'b0, n[5], 2'b01, n[2:0]};
      C_LOAD:  return {1'b0, n[5], 2'b00, n[2], 1'b1, n[0]};
      C_STORE: return {1'b0, n[5], 3'b001, 1'b0, n[0]};
      C_ALU:   return {1'b0, n[5], 5'b00001};
      default: return 7'b0;
    endcase
  endfunction

  // Append one cycle; pending retire strobes of the previous instruction land here.
  task automatic put(input logic r, input logic rs, input logic [6:0] fl, input logic bt,
                     input logic st, input logic ir, input logic rd, input logic bz,
                     input logic hl);
    if (t < MAXC) begin
      in_run[t] = r; in_rst[t] = rs; in_fl[t] = fl; in_bt[t] = bt;
`ifdef SINGLE_STEP_EN
      in_step[t] = st;
`endif
      if (p_pcu) m_cnt = (m_cnt + 1) % (1 << CNT_W);
      ex_o[t]   = {hl, bz, p_wr, rd, p_rw, p_sel, p_pcu, ir};
      ex_cnt[t] = m_cnt;
      p_pcu = 0; p_sel = 0; p_rw = 0; p_wr = 0;
      if (!rs) m_cnt = 0;
      t++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      put(1'b0, 1'b1, 7'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One instruction starting in S_IF; abort_k >= 0 pulls reset at that cycle.
  task automatic add_instr(input int c, input logic bt, input int abort_k, input bit use_step);
    logic [6:0] f, fl;
    logic r, st, b;
    int L;
    bit wb, samp;
    f  = cls_flags(c);
    L  = ins_len(c);
    wb = (c == C_ALU) || (c == C_JAL) || (c == C_LOAD);
    for (int k = 0; k < L; k++) begin
      samp = (k == 2) || (k == 3) || (wb && k == L - 1);
      fl   = samp ? f : 7'($urandom);
      b    = (k == 3) ? bt : 1'($urandom);
      r    = (k == 0) ? !use_step : 1'($urandom);
`ifdef SINGLE_STEP_EN
      st   = (k == 0) ? use_step : 1'($urandom);
`else
      st   = 1'b0;
`endif
      put(r, (k == abort_k) ? 1'b0 : 1'b1, fl, b, st, k == 2,
          (c == C_LOAD) && k >= 5 && k <= 5 + MEM_WAIT, k >= 1, 1'b0);
      if (k == abort_k) return;
    end
    if (c != C_HALT) begin
      p_pcu = 1;
      p_sel = (c == C_BR) ? bt : ((c == C_J) || (c == C_JAL));
      p_rw  = (c == C_ALU) || (c == C_JAL) || (c == C_LOAD);
      p_wr  = (c == C_STORE);
    end
  endtask

  task automatic halt_hold(input int n);
    for (int i = 0; i < n; i++)
      put(1'($urandom), 1'b1, 7'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b1, 1'b1);
    put(1'($urandom), 1'b0, 7'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    int c, ab;
    reset = 1'b0; run = 1'b0; branch_taken = 1'b0;
    {is_halt, is_jal, is_jump, is_branch, is_store, is_load, is_alu} = 7'b0;
`ifdef SINGLE_STEP_EN
    step = 1'b0;
`endif
    t = 0; m_cnt = 0; p_pcu = 0; p_sel = 0; p_rw = 0; p_wr = 0; cur_cyc = 0;

    idle(10);
    repeat (4) add_instr(C_ALU, 1'b0, -1, 0);
    add_instr(C_LOAD, 1'b0, -1, 0);
    add_instr(C_STORE, 1'b0, -1, 0);
    add_instr(C_BR, 1'b1, -1, 0);
    add_instr(C_BR, 1'b0, -1, 0);
    add_instr(C_JAL, 1'b0, -1, 0);
    add_instr(C_J, 1'b0, -1, 0);
    add_instr(C_NOP, 1'b0, -1, 0);
    idle(2);
    add_instr(C_LOAD, 1'b0, 5, 0);   // reset lands in S_MW
    idle(3);
    for (int n = 0; n < 160; n++) begin
      c  = $urandom_range(6, 0);
      ab = ($urandom_range(24, 0) == 0) ? $urandom_range(ins_len(c) - 1, 0) : -1;
      if ($urandom_range(3, 0) == 0) idle($urandom_range(2, 1));
      add_instr(c, 1'($urandom), ab, 0);
    end
`ifdef SINGLE_STEP_EN
    idle(1);
    put(1'b0, 1'b0, 7'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    for (int n = 0; n < 3; n++) begin
      c = $urandom_range(6, 0);
      add_instr(c, 1'($urandom), -1, 1);
      idle(10 - ins_len(c));
    end
`endif
    add_instr(C_HALT, 1'b0, -1, 0);
    halt_hold(8);
    idle(4);

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < t; i++) begin
      reset = in_rst[i];
      run   = in_run[i];
      {is_halt, is_jal, is_jump, is_branch, is_store, is_load, is_alu} = in_fl[i];
      branch_taken = in_bt[i];
`ifdef SINGLE_STEP_EN
      step = in_step[i];
`endif
      @(negedge clk);
      cur_cyc = i;
      chk("ir_load",          32'(ir_load),          32'(ex_o[i][0]));
      chk("pc_update",        32'(pc_update),        32'(ex_o[i][1]));
      chk("pc_sel_target",    32'(pc_sel_target),    32'(ex_o[i][2]));
      chk("reg_write_enable", 32'(reg_write_enable), 32'(ex_o[i][3]));
      chk("ram_read_enable",  32'(ram_read_enable),  32'(ex_o[i][4]));
      chk("ram_write_enable", 32'(ram_write_enable), 32'(ex_o[i][5]));
      chk("busy",             32'(busy),             32'(ex_o[i][6]));
      chk("halted",           32'(halted),           32'(ex_o[i][7]));
      chk("instr_count",      32'(instr_count),      32'(ex_cnt[i]));
      @(posedge clk);
      #1;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
